// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types for the operand forwarding unit.
// Stage tag layout, forwarding select encoding and tag helpers.
package fwd_pkg;

    // Widest register address and source count a tag can carry.
    localparam int TAG_AW  = 5;
    localparam int MAX_SRC = 3;

    typedef logic [TAG_AW-1:0] tag_addr_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                    valid;
        tag_addr_t               rd;
        logic                    reg_write;
        logic                    is_load;
        tag_addr_t [MAX_SRC-1:0] rs_addr;
        logic [MAX_SRC-1:0]      rs_used;
    } stage_tag_t;

    localparam stage_tag_t BUBBLE = '0;

    // A stage produces register a; x0 is never a real producer.
    function automatic logic writes_reg(stage_tag_t t, tag_addr_t a);
        return t.valid && t.reg_write && (t.rd == a) && (a != '0);
    endfunction

endpackage

// File: rtl/fwd_operand_mux.sv
// fwd_operand_mux: per-operand forwarding comparator and 3:1 mux.
// MEM is the younger producer, so it takes priority over WB.
module fwd_operand_mux
    import fwd_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic            src_used_i,
    input  tag_addr_t       src_addr_i,
    input  logic            mem_wr_i,
    input  tag_addr_t       mem_rd_i,
    input  logic            wb_wr_i,
    input  tag_addr_t       wb_rd_i,
    input  logic [XLEN-1:0] reg_data_i,
    input  logic [XLEN-1:0] mem_result_i,
    input  logic [XLEN-1:0] wb_result_i,
    output logic [XLEN-1:0] operand_o,
    output fwd_sel_e        sel_o
);

    logic src_live;
    logic mem_hit;
    logic wb_hit;

    assign src_live = FWD_EN && src_used_i && (src_addr_i != '0);
    assign mem_hit  = src_live && mem_wr_i && (mem_rd_i == src_addr_i);
    assign wb_hit   = src_live && wb_wr_i && (wb_rd_i == src_addr_i);

    // Pick the youngest matching producer, else the register file.
    always_comb begin
        sel_o     = FWD_REG;
        operand_o = reg_data_i;
        if (mem_hit) begin
            sel_o     = FWD_MEM;
            operand_o = mem_result_i;
        end else if (wb_hit) begin
            sel_o     = FWD_WB;
            operand_o = wb_result_i;
        end
    end

endmodule

// File: rtl/operand_forward_unit.sv
// operand_forward_unit: hazard detection and operand forwarding.
// Keeps its own EX/MEM/WB destination tags to drive stalls and muxes.
module operand_forward_unit
    import fwd_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_SRC    = 2,
    parameter int REG_ADDR_W = 5,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_addr,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic [REG_ADDR_W-1:0]         id_rd_addr,
    input  logic                          id_reg_write,
    input  logic                          id_is_load,
    input  logic                          flush,
    input  logic                          mem_ready,
    input  logic [NUM_SRC*XLEN-1:0]       ex_reg_data,
    input  logic [XLEN-1:0]               mem_result,
    input  logic [XLEN-1:0]               wb_result,
    output logic [NUM_SRC*XLEN-1:0]       ex_operand,
    output logic [NUM_SRC*2-1:0]          fwd_sel,
    output logic                          stall,
    output logic [31:0]                   stall_count
);

    stage_tag_t  ex_q, mem_q, wb_q;
    stage_tag_t  ex_d, mem_d, wb_d;
    stage_tag_t  id_tag;
    logic        mem_stall;
    logic        raw_hazard;
    logic        ex_bubble;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        mem_wr;
    logic        wb_wr;
    logic        ex_src_hits_mem_load;
    logic        unused_tag_bits;

    // Repack the decode fields into the shared tag format.
    always_comb begin
        id_tag           = BUBBLE;
        id_tag.valid     = 1'b1;
        id_tag.rd        = tag_addr_t'(id_rd_addr);
        id_tag.reg_write = id_reg_write;
        id_tag.is_load   = id_is_load;
        for (int i = 0; i < NUM_SRC; i++) begin
            id_tag.rs_addr[i] =
                tag_addr_t'(id_rs_addr[i*REG_ADDR_W +: REG_ADDR_W]);
            id_tag.rs_used[i] = id_rs_used[i];
        end
    end

    // Detect RAW hazards the datapath cannot cover by forwarding.
    always_comb begin
        raw_hazard = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_tag.rs_used[i]) begin
                if (FWD_EN) begin
                    if (writes_reg(ex_q, id_tag.rs_addr[i]) &&
                        ex_q.is_load)
                        raw_hazard = 1'b1;
                end else begin
                    if (writes_reg(ex_q, id_tag.rs_addr[i]) ||
                        writes_reg(mem_q, id_tag.rs_addr[i]) ||
                        writes_reg(wb_q, id_tag.rs_addr[i]))
                        raw_hazard = 1'b1;
                end
            end
        end
        raw_hazard = raw_hazard & id_valid;
    end

    assign mem_stall = mem_q.valid & mem_q.is_load & ~mem_ready;
    assign stall     = mem_stall | (raw_hazard & ~flush);
    assign ex_bubble = raw_hazard | flush | ~id_valid;

    // Advance the tag pipe unless memory is holding a load.
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (!mem_stall) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = ex_bubble ? BUBBLE : id_tag;
        end
    end

    // Saturating count of stalled cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // Tag and counter state; reset empties the pipe at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= BUBBLE;
            mem_q       <= BUBBLE;
            wb_q        <= BUBBLE;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

    // A load in MEM has no data yet, so it is never a forward source.
    assign mem_wr = mem_q.valid & mem_q.reg_write & ~mem_q.is_load;
    assign wb_wr  = wb_q.valid & wb_q.reg_write;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_sel_e sel_w;

        fwd_operand_mux #(
            .XLEN   (XLEN),
            .FWD_EN (FWD_EN)
        ) u_mux (
            .src_used_i   (ex_q.rs_used[g]),
            .src_addr_i   (ex_q.rs_addr[g]),
            .mem_wr_i     (mem_wr),
            .mem_rd_i     (mem_q.rd),
            .wb_wr_i      (wb_wr),
            .wb_rd_i      (wb_q.rd),
            .reg_data_i   (ex_reg_data[g*XLEN +: XLEN]),
            .mem_result_i (mem_result),
            .wb_result_i  (wb_result),
            .operand_o    (ex_operand[g*XLEN +: XLEN]),
            .sel_o        (sel_w)
        );

        assign fwd_sel[g*2 +: 2] = sel_w;
    end

    // The interlock keeps a consumer out of EX while its load is in MEM.
    always_comb begin
        ex_src_hits_mem_load = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ex_q.rs_used[i] && mem_q.is_load &&
                writes_reg(mem_q, ex_q.rs_addr[i]))
                ex_src_hits_mem_load = 1'b1;
        end
    end

    a_no_mem_load_fwd : assert property (
        @(posedge clk) disable iff (rst) !ex_src_hits_mem_load
    );

    // Source fields ride along in later stages but are not consulted.
    assign unused_tag_bits = ^{wb_q, mem_q.rs_addr, mem_q.rs_used,
                               ex_q.rs_addr, ex_q.rs_used};

endmodule

// File: tb/tb_operand_forward_unit.sv
// tb_operand_forward_unit: directed table, corner sequences and random
// traffic on a forwarding build and a no-forwarding build.
module tb_operand_forward_unit;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         id_valid = 1'b0;
    logic [9:0]   id_rs_addr = '0;
    logic [1:0]   id_rs_used = '0;
    logic [4:0]   id_rd_addr = '0;
    logic         id_reg_write = 1'b0;
    logic         id_is_load = 1'b0;
    logic         flush = 1'b0;
    logic         mem_ready = 1'b1;
    logic [63:0]  ex_reg_data = 64'hBBBB0001_AAAA0000;
    logic [31:0]  mem_result = 32'h1234;
    logic [31:0]  wb_result = 32'hCAFE;

    // Index 0: FWD_EN=0 build, index 1: FWD_EN=1 build.
    logic [1:0]   stall_v;
    logic [7:0]   sel_v;
    logic [127:0] op_v;
    logic [63:0]  cnt_v;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    operand_forward_unit #(
        .XLEN(32), .NUM_SRC(2), .REG_ADDR_W(5), .FWD_EN(1'b0)
    ) u_dut_nf (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .flush(flush), .mem_ready(mem_ready),
        .ex_reg_data(ex_reg_data), .mem_result(mem_result),
        .wb_result(wb_result), .ex_operand(op_v[63:0]),
        .fwd_sel(sel_v[3:0]), .stall(stall_v[0]),
        .stall_count(cnt_v[31:0])
    );

    operand_forward_unit #(
        .XLEN(32), .NUM_SRC(2), .REG_ADDR_W(5), .FWD_EN(1'b1)
    ) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
        .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .flush(flush), .mem_ready(mem_ready),
        .ex_reg_data(ex_reg_data), .mem_result(mem_result),
        .wb_result(wb_result), .ex_operand(op_v[127:64]),
        .fwd_sel(sel_v[7:4]), .stall(stall_v[1]),
        .stall_count(cnt_v[63:32])
    );

    // Reference model: a list of in-flight instructions per build.
    typedef struct packed {
        bit            v;
        bit [4:0]      rd;
        bit            we;
        bit            ld;
        bit [1:0][4:0] rs;
        bit [1:0]      used;
    } ins_t;

    ins_t        pipe [2][3];
    logic [31:0] mcnt [2];

    function automatic bit hit(ins_t t, bit [4:0] a);
        return t.v && t.we && (t.rd == a) && (a != 5'd0);
    endfunction

    function automatic ins_t cur_id();
        ins_t t;
        t.v = 1'b1;
        t.rd = id_rd_addr;
        t.we = id_reg_write;
        t.ld = id_is_load;
        t.rs[0] = id_rs_addr[4:0];
        t.rs[1] = id_rs_addr[9:5];
        t.used = id_rs_used;
        return t;
    endfunction

    function automatic bit m_mstall(int m);
        return pipe[m][1].v && pipe[m][1].ld && !mem_ready;
    endfunction

    function automatic bit m_raw(int m);
        bit r;
        ins_t t;
        r = 1'b0;
        t = cur_id();
        if (!id_valid) return 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (t.used[i]) begin
                if (m == 1)
                    r |= hit(pipe[m][0], t.rs[i]) && pipe[m][0].ld;
                else
                    r |= hit(pipe[m][0], t.rs[i]) ||
                         hit(pipe[m][1], t.rs[i]) ||
                         hit(pipe[m][2], t.rs[i]);
            end
        end
        return r;
    endfunction

    function automatic bit [1:0] m_sel(int m, int i);
        bit [4:0] a;
        if (m == 0 || !pipe[m][0].v || !pipe[m][0].used[i]) return 2'b00;
        a = pipe[m][0].rs[i];
        if (hit(pipe[m][1], a) && !pipe[m][1].ld) return 2'b10;
        if (hit(pipe[m][2], a)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_stall(int m);
        return m_mstall(m) || (m_raw(m) && !flush);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int s = 0; s < 3; s++) pipe[m][s] = '0;
            mcnt[m] = 32'd0;
        end
    endtask

    task automatic model_clock();
        for (int m = 0; m < 2; m++) begin
            bit st, ms, bub;
            st = m_stall(m);
            ms = m_mstall(m);
            bub = m_raw(m) || flush || !id_valid;
            if (st && mcnt[m] != 32'hFFFF_FFFF) mcnt[m] += 32'd1;
            if (!ms) begin
                pipe[m][2] = pipe[m][1];
                pipe[m][1] = pipe[m][0];
                pipe[m][0] = bub ? ins_t'(0) : cur_id();
            end
        end
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, want %0h",
                     nm, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        for (int m = 0; m < 2; m++) begin
            logic [3:0]  xs;
            logic [63:0] xo;
            for (int i = 0; i < 2; i++) begin
                bit [1:0] s;
                s = m_sel(m, i);
                xs[i*2 +: 2] = s;
                xo[i*32 +: 32] = (s == 2'b10) ? mem_result :
                                 (s == 2'b01) ? wb_result :
                                 ex_reg_data[i*32 +: 32];
            end
            chk($sformatf("model%0d stall", m),
                64'(stall_v[m]), 64'(m_stall(m)));
            chk($sformatf("model%0d fwd_sel", m),
                64'(sel_v[m*4 +: 4]), 64'(xs));
            chk($sformatf("model%0d operand", m), op_v[m*64 +: 64], xo);
            chk($sformatf("model%0d stall_count", m),
                64'(cnt_v[m*32 +: 32]), 64'(mcnt[m]));
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1-2 ns later.
    task automatic step();
        #1;
        check_model();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        cyc++;
    endtask

    task automatic drive(int v, int rs0, int rs1, int used, int rd,
                         int we, int ld, int fl, int rdy);
        id_valid     = (v != 0);
        id_rs_addr   = {5'(rs1), 5'(rs0)};
        id_rs_used   = 2'(used);
        id_rd_addr   = 5'(rd);
        id_reg_write = (we != 0);
        id_is_load   = (ld != 0);
        flush        = (fl != 0);
        mem_ready    = (rdy != 0);
    endtask

    task automatic reset_pulse();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int v, rs0, rs1, used, rd, we, ld, fl, rdy;
        int xs, xsel, xcnt;
    } vec_t;

    localparam int NVEC = 21;
    vec_t tbl [NVEC];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        // Cycle-by-cycle script for the FWD_EN=1 build; x-fields are
        // expected stall, fwd_sel {op1,op0} and stall_count before the edge.
        //          v rs0 rs1 use rd we ld fl rdy  xs xsel   xcnt
        tbl[0]  = '{1, 1,  2, 3,  5, 1, 0, 0, 1,  0, 'b0000, 0};
        tbl[1]  = '{1, 5,  6, 3,  8, 1, 0, 0, 1,  0, 'b0000, 0};
        tbl[2]  = '{0, 0,  0, 0,  0, 0, 0, 0, 1,  0, 'b0010, 0};
        tbl[3]  = '{1, 8,  0, 1,  0, 0, 0, 0, 1,  0, 'b0000, 0};
        tbl[4]  = '{1, 0,  0, 0, 10, 1, 0, 0, 1,  0, 'b0001, 0};
        tbl[5]  = '{1, 0,  0, 0, 10, 1, 0, 0, 1,  0, 'b0000, 0};
        tbl[6]  = '{1, 10, 10, 3, 0, 0, 0, 0, 1,  0, 'b0000, 0};
        tbl[7]  = '{1, 0,  0, 0,  7, 1, 1, 0, 1,  0, 'b1010, 0};
        tbl[8]  = '{1, 7,  3, 1,  0, 0, 0, 0, 1,  1, 'b0000, 0};
        tbl[9]  = '{1, 7,  3, 1,  0, 0, 0, 0, 1,  0, 'b0000, 1};
        tbl[10] = '{1, 0,  0, 0, 12, 1, 1, 0, 1,  0, 'b0001, 1};
        tbl[11] = '{1, 0,  0, 0,  0, 1, 0, 0, 1,  0, 'b0000, 1};
        tbl[12] = '{1, 0,  0, 3,  0, 0, 0, 0, 0,  1, 'b0000, 1};
        tbl[13] = '{1, 0,  0, 3,  0, 0, 0, 0, 0,  1, 'b0000, 2};
        tbl[14] = '{1, 0,  0, 3,  0, 0, 0, 0, 0,  1, 'b0000, 3};
        tbl[15] = '{1, 0,  0, 3,  0, 0, 0, 0, 1,  0, 'b0000, 4};
        tbl[16] = '{0, 0,  0, 0,  0, 0, 0, 0, 1,  0, 'b0000, 4};
        tbl[17] = '{1, 0,  0, 0,  7, 1, 1, 0, 1,  0, 'b0000, 4};
        tbl[18] = '{1, 7,  0, 1,  0, 0, 0, 1, 1,  0, 'b0000, 4};
        tbl[19] = '{0, 0,  0, 0,  0, 0, 0, 0, 1,  0, 'b0000, 4};
        tbl[20] = '{0, 0,  0, 0,  0, 0, 0, 0, 1,  0, 'b0000, 4};

        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        #1;
        chk("reset stall", 64'(stall_v[1]), 64'd0);
        chk("reset fwd_sel", 64'(sel_v[7:4]), 64'd0);
        chk("reset operand", op_v[127:64], 64'hBBBB0001_AAAA0000);
        chk("reset stall_count", 64'(cnt_v[63:32]), 64'd0);

        for (int r = 0; r < NVEC; r++) begin
            vec_t t;
            logic [31:0] xop0;
            t = tbl[r];
            drive(t.v, t.rs0, t.rs1, t.used, t.rd, t.we, t.ld, t.fl, t.rdy);
            xop0 = ((t.xsel & 3) == 2) ? 32'h1234 :
                   ((t.xsel & 3) == 1) ? 32'hCAFE : 32'hAAAA0000;
            #1;
            chk($sformatf("tbl%0d stall", r), 64'(stall_v[1]), 64'(t.xs));
            chk($sformatf("tbl%0d fwd_sel", r),
                64'(sel_v[7:4]), 64'(t.xsel));
            chk($sformatf("tbl%0d operand0", r),
                64'(op_v[95:64]), 64'(xop0));
            chk($sformatf("tbl%0d stall_count", r),
                64'(cnt_v[63:32]), 64'(t.xcnt));
            step();
        end

        // No-forwarding build: consumer waits until the writer retires.
        reset_pulse();
        drive(1, 0, 0, 0, 9, 1, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        drive(1, 9, 0, 1, 0, 0, 0, 0, 1);
        #1;
        chk("nofwd stall mem", 64'(stall_v[0]), 64'd1);
        step();
        #1;
        chk("nofwd stall wb", 64'(stall_v[0]), 64'd1);
        step();
        #1;
        chk("nofwd release", 64'(stall_v[0]), 64'd0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("nofwd fwd_sel", 64'(sel_v[3:0]), 64'd0);
        chk("nofwd stall_count", 64'(cnt_v[31:0]), 64'd2);
        chk("fwd stall_count", 64'(cnt_v[63:32]), 64'd0);
        step();

        // Asynchronous reset while a load is waiting on memory.
        reset_pulse();
        drive(1, 0, 0, 0, 4, 1, 1, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        #1;
        chk("memwait stall", 64'(stall_v[1]), 64'd1);
        chk("memwait stall_count", 64'(cnt_v[63:32]), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst stall", 64'(stall_v[1]), 64'd0);
        chk("rst stall nf", 64'(stall_v[0]), 64'd0);
        chk("rst stall_count", 64'(cnt_v[63:32]), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();

        // Random traffic over a small register window to force overlaps.
        for (int k = 0; k < 3000; k++) begin
            drive(int'($urandom_range(0, 9) < 8),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 9) < 3),
                  int'($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 9) < 7));
            ex_reg_data = {$urandom, $urandom};
            mem_result  = $urandom;
            wb_result   = $urandom;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
